exe_mem_stage: RTL and testbench

EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

---
 rtl/exe_mem_stage_pkg.sv | 53 +++++
 rtl/exe_mem_stage_alu32.sv | 54 +++++
 rtl/exe_mem_stage.sv | 100 ++++++++++
 tb/tb_exe_mem_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_stage_pkg.sv
// Shared pipeline definitions: ALU operation and bypass-select encodings,
// plus the EXE/MEM register layout and the bypass mux helper.
package exe_mem_stage_pkg;

    localparam int XLEN        = 32;
    localparam int RW_W        = 5;
    localparam int OVF_CNT_W   = 8;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

    typedef enum logic [2:0] {
        ALU_ADDU = 3'b000,
        ALU_SUBU = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SUB  = 3'b011,
        ALU_AND  = 3'b100,
        ALU_OR   = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_STAGE = 2'b00,
        FWD_MEM   = 2'b01,
        FWD_WB    = 2'b10,
        FWD_RSVD  = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic            mem_to_reg;
        logic            mem_wr;
        logic            reg_wr;
        logic [RW_W-1:0] rw;
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] bus_b;
        logic            zero;
        logic            overflow;
    } mem_reg_t;

    // The reserved select falls back to the stage input, same as 00.
    function automatic logic [XLEN-1:0] fwd_mux(
        input fwd_sel_e        sel,
        input logic [XLEN-1:0] stage_val,
        input logic [XLEN-1:0] mem_val,
        input logic [XLEN-1:0] wb_val
    );
        case (sel)
            FWD_MEM: fwd_mux = mem_val;
            FWD_WB:  fwd_mux = wb_val;
            default: fwd_mux = stage_val;
        endcase
    endfunction

endpackage

// File: rtl/exe_mem_stage_alu32.sv
// Combinational 32-bit ALU: arithmetic, logic and set-less-than operations
// with signed-overflow detection for the checked add/sub encodings only.
module alu32
    import exe_mem_stage_pkg::*;
(
    input  logic [2:0]      alu_ctr,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            add_ovf;
    logic            sub_ovf;
    logic            lt_signed;
    logic            lt_unsigned;

    assign sum         = a + b;
    assign diff        = a - b;
    // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
    assign add_ovf     = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1]  != a[XLEN-1]);
    assign sub_ovf     = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_op_e'(alu_ctr))
            ALU_ADDU: result = sum;
            ALU_SUBU: result = diff;
            ALU_ADD: begin
                result   = sum;
                overflow = add_ovf;
            end
            ALU_SUB: begin
                result   = diff;
                overflow = sub_ovf;
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline stage: operand bypassing, ALU, overflow gating of write
// enables, the EXE/MEM register with flush/stall, and an overflow counter.
module exe_mem_stage
    import exe_mem_stage_pkg::*;
(
    input  logic                 CLK,
    input  logic                 reset,

    input  logic                 EXE_MemtoReg,
    input  logic                 EXE_MemWr,
    input  logic                 EXE_RegWr_Org,
    input  logic [2:0]           EXE_ALUctr,
    input  logic [4:0]           EXE_Rw,
    input  logic [31:0]          EXE_BusA,
    input  logic [31:0]          EXE_B,
    input  logic [31:0]          EXE_BusB,

    input  logic [1:0]           ForwardA,
    input  logic [1:0]           ForwardB,
    input  logic [1:0]           ForwardS,
    input  logic [31:0]          WB_BusW,
    input  logic                 Stall,
    input  logic                 Flush,

    output logic                 MEM_MemtoReg,
    output logic                 MEM_MemWr,
    output logic                 MEM_RegWr,
    output logic [4:0]           MEM_Rw,
    output logic [31:0]          MEM_ALUout,
    output logic [31:0]          MEM_BusB,
    output logic                 MEM_Zero,
    output logic                 MEM_Overflow,
    output logic [7:0]           OvfCount
);

    mem_reg_t              mem_q;
    mem_reg_t              mem_d;
    logic [OVF_CNT_W-1:0]  ovf_cnt_q;

    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [XLEN-1:0]       store_data;
    logic [XLEN-1:0]       alu_result;
    logic                  alu_zero;
    logic                  alu_ovf;

    // Bypass from the value currently held in the EXE/MEM register, so a
    // dependent op in the very next cycle sees its producer's result.
    assign op_a       = fwd_mux(fwd_sel_e'(ForwardA), EXE_BusA, mem_q.alu_out, WB_BusW);
    assign op_b       = fwd_mux(fwd_sel_e'(ForwardB), EXE_B,    mem_q.alu_out, WB_BusW);
    assign store_data = fwd_mux(fwd_sel_e'(ForwardS), EXE_BusB, mem_q.alu_out, WB_BusW);

    alu32 u_alu (
        .alu_ctr  (EXE_ALUctr),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_ovf)
    );

    // An overflowing op must not commit: kill both register and memory writes.
    always_comb begin
        mem_d            = '0;
        mem_d.mem_to_reg = EXE_MemtoReg;
        mem_d.mem_wr     = EXE_MemWr     & ~alu_ovf;
        mem_d.reg_wr     = EXE_RegWr_Org & ~alu_ovf;
        mem_d.rw         = EXE_Rw;
        mem_d.alu_out    = alu_result;
        mem_d.bus_b      = store_data;
        mem_d.zero       = alu_zero;
        mem_d.overflow   = alu_ovf;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            mem_q     <= '0;
            ovf_cnt_q <= '0;
        end else if (Flush) begin
            mem_q     <= '0;
        end else if (!Stall) begin
            mem_q <= mem_d;
            if (mem_d.overflow && (ovf_cnt_q != OVF_CNT_MAX)) begin
                ovf_cnt_q <= ovf_cnt_q + 1'b1;
            end
        end
    end

    assign MEM_MemtoReg = mem_q.mem_to_reg;
    assign MEM_MemWr    = mem_q.mem_wr;
    assign MEM_RegWr    = mem_q.reg_wr;
    assign MEM_Rw       = mem_q.rw;
    assign MEM_ALUout   = mem_q.alu_out;
    assign MEM_BusB     = mem_q.bus_b;
    assign MEM_Zero     = mem_q.zero;
    assign MEM_Overflow = mem_q.overflow;
    assign OvfCount     = ovf_cnt_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: the driver queues hand-computed
// expectations per clock edge, a monitor pops and compares after each edge.
module tb_exe_mem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] busb;
        logic [4:0]  rw;
        logic        m2r;
        logic        mw;
        logic        rwe;
        logic        zero;
        logic        ovf;
        logic [7:0]  cnt;
    } obs_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        EXE_MemtoReg = 1'b0, EXE_MemWr = 1'b0, EXE_RegWr_Org = 1'b0;
    logic [2:0]  EXE_ALUctr = 3'b000;
    logic [4:0]  EXE_Rw = 5'd0;
    logic [31:0] EXE_BusA = '0, EXE_B = '0, EXE_BusB = '0;
    logic [1:0]  ForwardA = 2'b00, ForwardB = 2'b00, ForwardS = 2'b00;
    logic [31:0] WB_BusW = '0;
    logic        Stall = 1'b0, Flush = 1'b0;

    logic        MEM_MemtoReg, MEM_MemWr, MEM_RegWr;
    logic [4:0]  MEM_Rw;
    logic [31:0] MEM_ALUout, MEM_BusB;
    logic        MEM_Zero, MEM_Overflow;
    logic [7:0]  OvfCount;

    int          n_checks = 0;
    int          n_pass   = 0;
    obs_t        exp_q[$];
    string       name_q[$];
    obs_t        last_exp;

    exe_mem_stage dut (
        .CLK           (CLK),
        .reset         (reset),
        .EXE_MemtoReg  (EXE_MemtoReg),
        .EXE_MemWr     (EXE_MemWr),
        .EXE_RegWr_Org (EXE_RegWr_Org),
        .EXE_ALUctr    (EXE_ALUctr),
        .EXE_Rw        (EXE_Rw),
        .EXE_BusA      (EXE_BusA),
        .EXE_B         (EXE_B),
        .EXE_BusB      (EXE_BusB),
        .ForwardA      (ForwardA),
        .ForwardB      (ForwardB),
        .ForwardS      (ForwardS),
        .WB_BusW       (WB_BusW),
        .Stall         (Stall),
        .Flush         (Flush),
        .MEM_MemtoReg  (MEM_MemtoReg),
        .MEM_MemWr     (MEM_MemWr),
        .MEM_RegWr     (MEM_RegWr),
        .MEM_Rw        (MEM_Rw),
        .MEM_ALUout    (MEM_ALUout),
        .MEM_BusB      (MEM_BusB),
        .MEM_Zero      (MEM_Zero),
        .MEM_Overflow  (MEM_Overflow),
        .OvfCount      (OvfCount)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t mk(input logic [31:0] alu, input logic [31:0] busb,
                                input logic [4:0] rw, input logic m2r, input logic mw,
                                input logic rwe, input logic zero, input logic ovf,
                                input logic [7:0] cnt);
        obs_t o;
        o = '{alu: alu, busb: busb, rw: rw, m2r: m2r, mw: mw, rwe: rwe,
              zero: zero, ovf: ovf, cnt: cnt};
        return o;
    endfunction

    function automatic obs_t cur();
        return mk(MEM_ALUout, MEM_BusB, MEM_Rw, MEM_MemtoReg, MEM_MemWr,
                  MEM_RegWr, MEM_Zero, MEM_Overflow, OvfCount);
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got alu=%h busb=%h rw=%0d m2r=%b mw=%b rw_en=%b z=%b ovf=%b cnt=%0d, want alu=%h busb=%h rw=%0d m2r=%b mw=%b rw_en=%b z=%b ovf=%b cnt=%0d",
                     name, got.alu, got.busb, got.rw, got.m2r, got.mw, got.rwe, got.zero, got.ovf, got.cnt,
                     exp.alu, exp.busb, exp.rw, exp.m2r, exp.mw, exp.rwe, exp.zero, exp.ovf, exp.cnt);
        end
    endtask

    // Queue the expectation for the coming edge, then move to the next falling edge.
    task automatic expect_edge(input string name, input obs_t e);
        exp_q.push_back(e);
        name_q.push_back(name);
        last_exp = e;
        @(negedge CLK);
    endtask

    task automatic op(input logic [2:0] ctr, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] s);
        EXE_ALUctr = ctr;
        EXE_BusA   = a;
        EXE_B      = b;
        EXE_BusB   = s;
        ForwardA   = 2'b00;
        ForwardB   = 2'b00;
        ForwardS   = 2'b00;
    endtask

    // Monitor: the register presents a new value after every rising edge.
    initial begin
        obs_t  e;
        string n;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, cur(), e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t zero_obs;
        zero_obs = '0;

        Stall = 1'b1;
        Flush = 1'b0;
        EXE_RegWr_Org = 1'b1;
        op(3'b000, 32'h1234, 32'h1, 32'h5);
        repeat (2) @(negedge CLK);
        check("reset_state", cur(), zero_obs);
        Stall = 1'b0;
        reset = 1'b1;

        EXE_MemtoReg = 1'b0; EXE_MemWr = 1'b1; EXE_RegWr_Org = 1'b1; EXE_Rw = 5'd5;
        op(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h11);
        expect_edge("add_ovf", mk(32'h8000_0000, 32'h11, 5, 0, 0, 0, 0, 1, 1));
        op(3'b000, 32'h7FFF_FFFF, 32'h1, 32'h11);
        expect_edge("addu_wrap", mk(32'h8000_0000, 32'h11, 5, 0, 1, 1, 0, 0, 1));

        EXE_MemWr = 1'b0; EXE_MemtoReg = 1'b1; EXE_Rw = 5'd7;
        op(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h0);
        expect_edge("slt_neg", mk(32'h1, 0, 7, 1, 0, 1, 0, 0, 1));
        op(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h0);
        expect_edge("sltu_big", mk(32'h0, 0, 7, 1, 0, 1, 1, 0, 1));

        EXE_MemtoReg = 1'b0;
        op(3'b100, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0);
        expect_edge("and_zero", mk(32'h0, 0, 7, 0, 0, 1, 1, 0, 1));
        op(3'b101, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0);
        expect_edge("or", mk(32'h0000_FFFF, 0, 7, 0, 0, 1, 0, 0, 1));
        op(3'b011, 32'h8000_0000, 32'h1, 32'h0);
        expect_edge("sub_ovf", mk(32'h7FFF_FFFF, 0, 7, 0, 0, 0, 0, 1, 2));
        op(3'b001, 32'h8000_0000, 32'h1, 32'h0);
        expect_edge("subu_wrap", mk(32'h7FFF_FFFF, 0, 7, 0, 0, 1, 0, 0, 2));

        EXE_Rw = 5'd3;
        op(3'b000, 32'd5, 32'd3, 32'h0);
        expect_edge("addu_5_3", mk(32'd8, 0, 3, 0, 0, 1, 0, 0, 2));
        op(3'b001, 32'h100, 32'd2, 32'h55);
        ForwardA = 2'b01; ForwardS = 2'b10; WB_BusW = 32'hDEAD_BEEF;
        expect_edge("fwd_mem_a_wb_s", mk(32'd6, 32'hDEAD_BEEF, 3, 0, 0, 1, 0, 0, 2));
        op(3'b000, 32'h100, 32'h999, 32'h55);
        ForwardA = 2'b01; ForwardB = 2'b10; ForwardS = 2'b01; WB_BusW = 32'd16;
        expect_edge("fwd_mem_a_wb_b", mk(32'd22, 32'd6, 3, 0, 0, 1, 0, 0, 2));
        op(3'b000, 32'h40, 32'h2, 32'h77);
        ForwardA = 2'b11; ForwardB = 2'b11; ForwardS = 2'b11;
        expect_edge("fwd_rsvd", mk(32'h42, 32'h77, 3, 0, 0, 1, 0, 0, 2));

        #1 reset = 1'b0;
        #1 check("async_reset", cur(), zero_obs);
        #1 reset = 1'b1;
        expect_edge("reset_resume", mk(32'h42, 32'h77, 3, 0, 0, 1, 0, 0, 0));

        EXE_Rw = 5'd9;
        op(3'b000, 32'd1, 32'd2, 32'hAB);
        expect_edge("pre_stall", mk(32'd3, 32'hAB, 9, 0, 0, 1, 0, 0, 0));
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            EXE_Rw = 5'(i + 1); EXE_MemWr = 1'b1; EXE_MemtoReg = i[0];
            op(3'b010, 32'h7FFF_FFFF, 32'(i + 1), 32'(i * 7 + 1));
            expect_edge($sformatf("stall_hold_%0d", i), last_exp);
        end
        Flush = 1'b1;
        expect_edge("stall_flush", zero_obs);
        Flush = 1'b0; Stall = 1'b0; EXE_MemtoReg = 1'b0;

        EXE_Rw = 5'd4; EXE_MemWr = 1'b1; EXE_RegWr_Org = 1'b1;
        op(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h0);
        for (int i = 1; i <= 256; i++) begin
            expect_edge($sformatf("ovf_cnt_%0d", i),
                        mk(32'h8000_0000, 0, 4, 0, 0, 0, 0, 1, (i > 255) ? 8'd255 : 8'(i)));
        end
        Stall = 1'b1;
        op(3'b000, 32'd1, 32'd1, 32'h0);
        expect_edge("sat_stall", last_exp);
        #2 reset = 1'b0;
        #1 check("reset_mid_stall", cur(), zero_obs);
        #1 reset = 1'b1;
        expect_edge("stall_after_reset", zero_obs);
        Stall = 1'b0;
        expect_edge("load_after_reset", mk(32'd2, 0, 4, 0, 1, 1, 0, 0, 0));

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
